// File: rtl/bf_pkg.sv
// Shared definitions for the bf_core multi-cycle processor:
// opcodes, instruction field positions, sequencer states and ALU ops.
package bf_pkg;

  localparam logic [3:0] OP_JMP  = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LODI = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;
  localparam logic [3:0] OP_JEQZ = 4'd7;
  localparam logic [3:0] OP_SUB  = 4'd8;
  localparam logic [3:0] OP_JNEZ = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam int OP_HI = 7;
  localparam int OP_LO = 4;
  localparam int RA_HI = 3;
  localparam int RA_LO = 0;
  localparam int RB_HI = 7;
  localparam int RB_LO = 4;
  localparam int RC_HI = 3;
  localparam int RC_LO = 0;

  typedef enum logic [2:0] {
    FETCH0,
    FETCH1,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_NAND,
    ALU_PASS
  } alu_op_t;

endpackage

// File: rtl/bf_alu.sv
// Combinational datapath ALU: add, subtract, nand or pass b,
// with a zero flag on the result.
module bf_alu
  import bf_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              zero
);

  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_NAND: y = ~(a & b);
      ALU_PASS: y = b;
      default:  y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/bf_core.sv
// Multi-cycle bf processor: one FSM sequences fetch, execute,
// memory and writeback over a single registered request/ready bus.
module bf_core
  import bf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREGS  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              halted,
  output logic [CNT_W-1:0]  icount
);

  localparam logic [15:0] REG_MASK =
    16'((33'd1 << NREGS) - 33'd1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx, w1_addr;
  logic [DATA_W-1:0] ir0, ir1, res;
  logic              zero_q;
  logic [DATA_W-1:0] regs [16];
  logic [3:0]        op, ra, rb, rc;
  logic [DATA_W-1:0] ra_val, rb_val, rc_val;
  logic [DATA_W-1:0] alu_a, alu_b, alu_y;
  logic              alu_zero;
  alu_op_t           alu_op;
  logic is_jmp, is_lod, is_str, is_add, is_addi, is_lodi;
  logic is_nand, is_jeqz, is_sub, is_jnez, is_halt;
  logic is_mem, is_wr, xfer;
  logic fetch_issue, take_w0, take_w1;
  logic mem_issue, mem_done, retire, halt_entry;

  assign op = ir0[OP_HI:OP_LO];
  assign ra = ir0[RA_HI:RA_LO];
  assign rb = ir1[RB_HI:RB_LO];
  assign rc = ir1[RC_HI:RC_LO];
  assign w1_addr = ADDR_W'(ir1);

  // Unimplemented register indices read as zero.
  assign ra_val = REG_MASK[ra] ? regs[ra] : '0;
  assign rb_val = REG_MASK[rb] ? regs[rb] : '0;
  assign rc_val = REG_MASK[rc] ? regs[rc] : '0;

  assign is_jmp  = (op == OP_JMP);
  assign is_lod  = (op == OP_LOD);
  assign is_str  = (op == OP_STR);
  assign is_add  = (op == OP_ADD);
  assign is_addi = (op == OP_ADDI);
  assign is_lodi = (op == OP_LODI);
  assign is_nand = (op == OP_NAND);
  assign is_jeqz = (op == OP_JEQZ);
  assign is_sub  = (op == OP_SUB);
  assign is_jnez = (op == OP_JNEZ);
  assign is_halt = (op == OP_HALT);
  assign is_mem  = is_lod | is_str;
  assign is_wr   = is_lod | is_add | is_sub | is_nand
                 | is_addi | is_lodi;
  assign xfer    = mem_req & mem_ready;

  always_comb begin
    alu_op = ALU_PASS;
    alu_a  = rb_val;
    alu_b  = rc_val;
    unique case (1'b1)
      is_add:  alu_op = ALU_ADD;
      is_sub:  alu_op = ALU_SUB;
      is_nand: alu_op = ALU_NAND;
      is_addi: begin
        alu_op = ALU_ADD;
        alu_a  = ra_val;
        alu_b  = ir1;
      end
      is_lodi: alu_b = ir1;
      is_jeqz, is_jnez: alu_b = ra_val;
      default: ;
    endcase
  end

  bf_alu #(.DATA_W(DATA_W)) u_alu (
    .op   (alu_op),
    .a    (alu_a),
    .b    (alu_b),
    .y    (alu_y),
    .zero (alu_zero)
  );

  always_comb begin
    pc_nx = pc + ADDR_W'(2);
    if (is_jmp || (is_jeqz && zero_q) ||
        (is_jnez && !zero_q))
      pc_nx = w1_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH0;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH0: if (xfer) state_nx = FETCH1;
      FETCH1: if (xfer) state_nx = DECODE;
      DECODE: state_nx = EXEC;
      EXEC: begin
        if (is_halt)     state_nx = HALT;
        else if (is_mem) state_nx = MEM;
        else             state_nx = WB;
      end
      MEM:  if (xfer) state_nx = WB;
      WB:   state_nx = FETCH0;
      HALT: state_nx = HALT;
      default: state_nx = FETCH0;
    endcase
  end

  always_comb begin
    fetch_issue = 1'b0;
    take_w0     = 1'b0;
    take_w1     = 1'b0;
    mem_issue   = 1'b0;
    mem_done    = 1'b0;
    retire      = 1'b0;
    halt_entry  = 1'b0;
    unique case (state)
      FETCH0: begin
        fetch_issue = !mem_req;
        take_w0     = xfer;
      end
      FETCH1: take_w1 = xfer;
      EXEC: begin
        mem_issue  = is_mem;
        halt_entry = is_halt;
      end
      MEM: mem_done = xfer;
      WB:  retire = 1'b1;
      default: ;
    endcase
  end

  // W1 is requested straight after W0 so zero-wait fetch is 2 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      icount    <= '0;
      pc        <= '0;
      ir0       <= '0;
      ir1       <= '0;
      res       <= '0;
      zero_q    <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      if (fetch_issue) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= pc;
      end
      if (take_w0) begin
        ir0      <= mem_rdata;
        mem_addr <= pc + ADDR_W'(1);
      end
      if (take_w1) begin
        ir1     <= mem_rdata;
        mem_req <= 1'b0;
      end
      if (state == EXEC) begin
        res    <= alu_y;
        zero_q <= alu_zero;
      end
      if (mem_issue) begin
        mem_req   <= 1'b1;
        mem_we    <= is_str;
        mem_addr  <= w1_addr;
        mem_wdata <= ra_val;
      end
      if (mem_done) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (is_lod) res <= mem_rdata;
      end
      if (halt_entry) begin
        halted <= 1'b1;
        icount <= icount + CNT_W'(1);
      end
      if (retire) begin
        pc       <= pc_nx;
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= pc_nx;
        icount   <= icount + CNT_W'(1);
        if (is_wr && REG_MASK[ra]) regs[ra] <= res;
      end
    end
  end

endmodule

// File: tb/tb_bf_core.sv
// Directed bench for bf_core: ALU vector table plus hand sequences
// for wait states, branches, boundaries and reset mid-transfer.
module tb_bf_core;

  logic       clk = 1'b0;
  logic       rst_a, ready_a, req_a, we_a, halted_a;
  logic [7:0] rdata_a, addr_a, wdata_a;
  logic [15:0] icount_a;
  logic       rst_b, ready_b, req_b, we_b, halted_b;
  logic [7:0] rdata_b, wdata_b;
  logic [3:0] addr_b;
  logic [15:0] icount_b;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [16];

  int nchecks = 0;
  int nerr = 0;
  int nwait = 0;
  int wcnt = 0;
  int nwr = 0;
  int nrd20 = 0;
  int nviol = 0;
  bit pend = 1'b0;
  logic [7:0] p_addr, p_wdata;
  logic p_we;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [9];

  always #5 clk = ~clk;

  assign rdata_a = mem_a[addr_a];
  assign rdata_b = mem_b[addr_b];

  bf_core #(
    .DATA_W(8), .ADDR_W(8), .NREGS(16), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst_a),
    .mem_ready(ready_a), .mem_rdata(rdata_a),
    .mem_req(req_a), .mem_we(we_a),
    .mem_addr(addr_a), .mem_wdata(wdata_a),
    .halted(halted_a), .icount(icount_a)
  );

  bf_core #(
    .DATA_W(8), .ADDR_W(4), .NREGS(4), .CNT_W(16)
  ) dut_b (
    .clk(clk), .rst(rst_b),
    .mem_ready(ready_b), .mem_rdata(rdata_b),
    .mem_req(req_b), .mem_we(we_b),
    .mem_addr(addr_b), .mem_wdata(wdata_b),
    .halted(halted_b), .icount(icount_b)
  );

  // Ready for the coming edge is chosen on the falling edge.
  initial begin
    ready_a = 1'b0;
    forever begin
      @(negedge clk);
      if (nwait == 0) ready_a = 1'b1;
      else if (!req_a) begin
        ready_a = 1'b0;
        wcnt = 0;
      end else if (wcnt >= nwait) begin
        ready_a = 1'b1;
        wcnt = 0;
      end else begin
        ready_a = 1'b0;
        wcnt++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (req_a && ready_a) begin
        if (we_a) begin
          mem_a[addr_a] = wdata_a;
          nwr++;
        end else if (addr_a == 8'h20) nrd20++;
      end
      if (pend && (!req_a || addr_a != p_addr ||
          we_a != p_we || wdata_a != p_wdata))
        nviol++;
      pend = req_a && !ready_a;
      p_addr = addr_a;
      p_we = we_a;
      p_wdata = wdata_a;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (req_b && ready_b && we_b) mem_b[addr_b] = wdata_b;
    end
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic prep_a();
    rst_a = 1'b1;
    for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
  endtask

  task automatic put_a(input logic [7:0] ad,
                       input logic [7:0] w0,
                       input logic [7:0] w1);
    mem_a[ad] = w0;
    mem_a[ad + 8'd1] = w1;
  endtask

  task automatic run_a(input int nw, input int budget,
                       output int cyc);
    rst_a = 1'b1;
    nwait = nw;
    @(negedge clk);
    @(negedge clk);
    nwr = 0;
    nrd20 = 0;
    nviol = 0;
    rst_a = 1'b0;
    cyc = 0;
    while (!halted_a && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("halt_reached", halted_a, 1);
  endtask

  initial begin
    int cyc;
    int n;
    int bad;
    rst_a = 1'b1;
    rst_b = 1'b1;
    ready_b = 1'b1;
    for (int i = 0; i < 16; i++) mem_b[i] = 8'h00;
    vecs[0] = {4'h3, 8'h12, 8'h34, 8'h46};
    vecs[1] = {4'h3, 8'hF0, 8'h20, 8'h10};
    vecs[2] = {4'h8, 8'h05, 8'h03, 8'h02};
    vecs[3] = {4'h8, 8'h03, 8'h05, 8'hFE};
    vecs[4] = {4'h6, 8'hF0, 8'hCC, 8'h3F};
    vecs[5] = {4'h6, 8'hFF, 8'hFF, 8'h00};
    vecs[6] = {4'h4, 8'h80, 8'h80, 8'h00};
    vecs[7] = {4'h4, 8'h10, 8'h05, 8'h15};
    vecs[8] = {4'hA, 8'h5A, 8'h11, 8'h5A};
    prep_a();
    repeat (2) @(negedge clk);
    check("reset_state",
          {req_a, we_a, addr_a, wdata_a, halted_a, icount_a}, 0);

    // LODI r1,5; LODI r2,3; SUB r3,r1,r2; HALT
    prep_a();
    put_a(8'h00, 8'h51, 8'h05);
    put_a(8'h02, 8'h52, 8'h03);
    put_a(8'h04, 8'h83, 8'h12);
    put_a(8'h06, 8'hF0, 8'h00);
    run_a(0, 100, cyc);
    check("halt_cycle", cyc, 20);
    check("sub_icount", icount_a, 4);
    check("sub_r3", dut_a.regs[3], 8'h02);
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (req_a) bad++;
    end
    check("no_req_after_halt", bad, 0);

    for (int i = 0; i < 9; i++) begin
      prep_a();
      put_a(8'h00, 8'h51, vecs[i].a);
      put_a(8'h02, 8'h52, vecs[i].b);
      put_a(8'h04, 8'h53, vecs[i].a);
      if (vecs[i].op == 4'h4) put_a(8'h06, 8'h43, vecs[i].b);
      else put_a(8'h06, {vecs[i].op, 4'h3}, 8'h12);
      put_a(8'h08, 8'h23, 8'h80);
      put_a(8'h0A, 8'hF0, 8'h00);
      mem_a[8'h80] = 8'hEE;
      run_a(0, 100, cyc);
      check($sformatf("vec%0d_result", i),
            mem_a[8'h80], vecs[i].exp);
      check($sformatf("vec%0d_icount", i), icount_a, 6);
    end

    // LODI r1,FF; ADDI r1,2; STR r1,40; HALT
    prep_a();
    put_a(8'h00, 8'h51, 8'hFF);
    put_a(8'h02, 8'h41, 8'h02);
    put_a(8'h04, 8'h21, 8'h40);
    put_a(8'h06, 8'hF0, 8'h00);
    run_a(0, 100, cyc);
    check("wrap_store", mem_a[8'h40], 8'h01);
    check("wrap_one_write", nwr, 1);

    // LOD r0,20; STR r0,60; HALT with 3 wait cycles per request
    prep_a();
    put_a(8'h00, 8'h10, 8'h20);
    put_a(8'h02, 8'h20, 8'h60);
    put_a(8'h04, 8'hF0, 8'h00);
    mem_a[8'h20] = 8'hA5;
    run_a(3, 300, cyc);
    check("wait_lod_data", mem_a[8'h60], 8'hA5);
    check("wait_single_read", nrd20, 1);
    check("wait_bus_stable", nviol, 0);
    check("wait_icount", icount_a, 3);

    // JEQZ taken, JNEZ falls through
    prep_a();
    put_a(8'h00, 8'h54, 8'h00);
    put_a(8'h02, 8'h74, 8'h10);
    put_a(8'h04, 8'h56, 8'hEE);
    put_a(8'h06, 8'h26, 8'h51);
    put_a(8'h08, 8'hF0, 8'h00);
    put_a(8'h10, 8'h94, 8'h30);
    put_a(8'h12, 8'h55, 8'h77);
    put_a(8'h14, 8'h25, 8'h50);
    put_a(8'h16, 8'hF0, 8'h00);
    put_a(8'h30, 8'hF0, 8'h00);
    run_a(0, 100, cyc);
    check("br_path", mem_a[8'h50], 8'h77);
    check("br_skip", mem_a[8'h51], 8'h00);
    check("br_icount", icount_a, 6);

    // JEQZ falls through, JNEZ taken
    prep_a();
    put_a(8'h00, 8'h54, 8'h01);
    put_a(8'h02, 8'h74, 8'h08);
    put_a(8'h04, 8'h94, 8'h20);
    put_a(8'h06, 8'hF0, 8'h00);
    put_a(8'h08, 8'hF0, 8'h00);
    put_a(8'h20, 8'h55, 8'h42);
    put_a(8'h22, 8'h25, 8'h50);
    put_a(8'h24, 8'hF0, 8'h00);
    run_a(0, 100, cyc);
    check("br2_path", mem_a[8'h50], 8'h42);
    check("br2_icount", icount_a, 6);

    // Reset while a store waits for ready
    prep_a();
    put_a(8'h00, 8'h51, 8'h5A);
    put_a(8'h02, 8'h21, 8'h70);
    put_a(8'h04, 8'hF0, 8'h00);
    nwait = 0;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!we_a && n < 50);
    check("rst_store_issued", we_a, 1);
    nwait = 1000;
    @(negedge clk);
    #2;
    rst_a = 1'b1;
    #1;
    check("rst_req_async", req_a, 0);
    check("rst_outputs",
          {we_a, addr_a, wdata_a, halted_a, icount_a}, 0);
    check("rst_abandoned", mem_a[8'h70], 8'h00);
    nwait = 0;
    @(negedge clk);
    rst_a = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!req_a && n < 10);
    check("restart_req", req_a, 1);
    check("restart_addr", addr_a, 8'h00);
    n = 0;
    while (!halted_a && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("restart_store", mem_a[8'h70], 8'h5A);
    check("restart_icount", icount_a, 3);

    // ADDR_W=4, NREGS=4: instruction at 0xF and r7 discarded
    mem_b[0]  = 8'h0A;
    mem_b[1]  = 8'h0F;
    mem_b[2]  = 8'h03;
    mem_b[3]  = 8'h21;
    mem_b[4]  = 8'h0D;
    mem_b[5]  = 8'h57;
    mem_b[6]  = 8'h55;
    mem_b[7]  = 8'h27;
    mem_b[8]  = 8'h0E;
    mem_b[9]  = 8'hF0;
    mem_b[13] = 8'h33;
    mem_b[14] = 8'h33;
    mem_b[15] = 8'h51;
    @(negedge clk);
    rst_b = 1'b0;
    n = 0;
    while (!halted_b && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b_halted", halted_b, 1);
    check("b_wrap_w1", mem_b[13], 8'h0A);
    check("b_r7_zero", mem_b[14], 8'h00);
    check("b_icount", icount_b, 7);

    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerr);
    $finish;
  end

endmodule
